execute_stage: RTL and testbench

EXECUTE_STAGE -- requirements
Module: execute_stage

---
 rtl/nark_pkg.sv | 41 ++++
 rtl/seq_multiplier.sv | 80 ++++++++
 rtl/execute_stage.sv | 208 ++++++++++++++++++++
 tb/tb_execute_stage.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nark_pkg.sv
// ============================================================================
// Module   : nark_pkg
// Purpose  : Shared types for the execute stage: ALU opcode encoding, execute
//            FSM states and the {N,Z,C,V} condition-flag record.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package nark_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLL = 3'd5,
    OP_SRL = 3'd6,
    OP_MUL = 3'd7
  } alu_op_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } ex_state_e;

  // Field order gives FlagsE[3]=N, [2]=Z, [1]=C, [0]=V.
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  // Width of the shift-amount field taken from operand B.
  localparam int c_SHAMT_W = 5;

endpackage

`default_nettype wire

// File: rtl/seq_multiplier.sv
// ============================================================================
// Module   : seq_multiplier
// Purpose  : Iterative shift-add multiplier, one multiplier bit per cycle,
//            always exactly BITS iterations. Product is the low BITS bits.
// Ports    : CLK        - clock, rising edge
//            RST        - synchronous reset, active low
//            i_start    - load operands and begin (ignored while aborting)
//            i_abort    - drop any multiply in progress
//            i_a, i_b   - multiplicand, multiplier
//            o_done     - high during the cycle whose edge ends the last step
//            o_product  - valid while o_done is high
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_multiplier
  import nark_pkg::*;
#(
  parameter int BITS = 24
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            i_start,
  input  logic            i_abort,
  input  logic [BITS-1:0] i_a,
  input  logic [BITS-1:0] i_b,
  output logic            o_done,
  output logic [BITS-1:0] o_product
);

  localparam int                CNT_W  = $clog2(BITS);
  localparam logic [CNT_W-1:0]  c_LAST = CNT_W'(BITS - 1);

  logic [BITS-1:0]  r_mcand;
  logic [BITS-1:0]  r_mplier;
  logic [BITS-1:0]  r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic [BITS-1:0]  w_acc_next;

  // Multiplicand shifts left and multiplier shifts right each step, so bit 0
  // of r_mplier always selects whether the current partial product is added.
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign o_done     = r_busy && (r_cnt == c_LAST);
  // The final accumulation is presented combinationally so the caller can
  // register it on the same edge that completes the last iteration.
  assign o_product  = w_acc_next;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_abort) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (i_start) begin
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      if (r_cnt == c_LAST) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/execute_stage.sv
// ============================================================================
// Module   : execute_stage
// Purpose  : Pipeline execute stage. Single-cycle ALU ops (ADD/SUB/AND/OR/
//            XOR/SLL/SRL) and a BITS-cycle iterative MUL that stalls decode.
// Ports    : CLK, RST (sync, active low)
//            ValidD, ALUControlD, SrcAD, SrcBD, WriteDataD, WA4D, MemWriteD
//                     - instruction from decode
//            FlushE   - kill incoming / in-flight instruction
//            StallD   - decode must hold its outputs (combinational)
//            ALUResultE, FlagsE, WriteDataE, WA4E, MemWriteE, ValidE
//                     - registered results to the memory stage
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module execute_stage
  import nark_pkg::*;
#(
  parameter int BITS = 24
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            ValidD,
  input  logic [2:0]      ALUControlD,
  input  logic [BITS-1:0] SrcAD,
  input  logic [BITS-1:0] SrcBD,
  input  logic [BITS-1:0] WriteDataD,
  input  logic [3:0]      WA4D,
  input  logic            MemWriteD,
  input  logic            FlushE,
  output logic            StallD,
  output logic [BITS-1:0] ALUResultE,
  output logic [BITS-1:0] WriteDataE,
  output logic [3:0]      WA4E,
  output logic            MemWriteE,
  output logic            ValidE,
  output logic [3:0]      FlagsE
);

  localparam logic [c_SHAMT_W:0] c_BITS_EXT = (c_SHAMT_W + 1)'(BITS);

  ex_state_e       r_state;
  logic [BITS-1:0] r_result;
  logic [BITS-1:0] r_wdata;
  logic [3:0]      r_wa;
  logic            r_mw;
  logic            r_valid;
  flags_t          r_flags;
  // Side-band fields of the multiply in flight, released with the product.
  logic [BITS-1:0] r_hold_wd;
  logic [3:0]      r_hold_wa;
  logic            r_hold_mw;

  alu_op_e              w_op;
  logic                 w_is_mul;
  logic [BITS:0]        w_sum;
  logic [BITS:0]        w_diff;
  logic [c_SHAMT_W-1:0] w_shamt;
  logic                 w_sh_oob;
  logic [BITS-1:0]      w_res;
  logic                 w_c;
  logic                 w_v;
  flags_t               w_flags;
  flags_t               w_mul_flags;
  logic                 w_mul_start;
  logic                 w_mul_done;
  logic [BITS-1:0]      w_mul_prod;

  assign w_op     = alu_op_e'(ALUControlD);
  assign w_is_mul = (w_op == OP_MUL);

  // SUB is A + ~B + 1, so the top bit is the carry, i.e. NOT borrow.
  assign w_sum    = {1'b0, SrcAD} + {1'b0, SrcBD};
  assign w_diff   = {1'b0, SrcAD} + {1'b0, ~SrcBD} + {{BITS{1'b0}}, 1'b1};
  assign w_shamt  = SrcBD[c_SHAMT_W-1:0];
  assign w_sh_oob = ({1'b0, w_shamt} >= c_BITS_EXT);

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_res = w_sum[BITS-1:0];
        w_c   = w_sum[BITS];
        w_v   = (SrcAD[BITS-1] == SrcBD[BITS-1]) && (w_sum[BITS-1] != SrcAD[BITS-1]);
      end
      OP_SUB: begin
        w_res = w_diff[BITS-1:0];
        w_c   = w_diff[BITS];
        w_v   = (SrcAD[BITS-1] != SrcBD[BITS-1]) && (w_diff[BITS-1] != SrcAD[BITS-1]);
      end
      OP_AND:  w_res = SrcAD & SrcBD;
      OP_OR:   w_res = SrcAD | SrcBD;
      OP_XOR:  w_res = SrcAD ^ SrcBD;
      OP_SLL:  w_res = w_sh_oob ? '0 : (SrcAD << w_shamt);
      OP_SRL:  w_res = w_sh_oob ? '0 : (SrcAD >> w_shamt);
      default: w_res = '0;
    endcase
  end

  always_comb begin
    w_flags   = '0;
    w_flags.n = w_res[BITS-1];
    w_flags.z = (w_res == '0);
    w_flags.c = w_c;
    w_flags.v = w_v;
  end

  always_comb begin
    w_mul_flags   = '0;
    w_mul_flags.n = w_mul_prod[BITS-1];
    w_mul_flags.z = (w_mul_prod == '0);
  end

  assign w_mul_start = (r_state == ST_IDLE) && ValidD && w_is_mul && !FlushE;

  seq_multiplier #(
    .BITS (BITS)
  ) u_mul (
    .CLK       (CLK),
    .RST       (RST),
    .i_start   (w_mul_start),
    .i_abort   (FlushE),
    .i_a       (SrcAD),
    .i_b       (SrcBD),
    .o_done    (w_mul_done),
    .o_product (w_mul_prod)
  );

  // Stall covers the presenting cycle plus BITS-1 multiply cycles; it drops in
  // the final iteration so decode can advance onto the edge that frees the ALU.
  always_comb begin
    StallD = 1'b0;
    case (r_state)
      ST_IDLE: StallD = ValidD && w_is_mul;
      ST_MUL:  StallD = !w_mul_done;
      default: StallD = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state   <= ST_IDLE;
      r_result  <= '0;
      r_wdata   <= '0;
      r_wa      <= '0;
      r_mw      <= 1'b0;
      r_valid   <= 1'b0;
      r_flags   <= '0;
      r_hold_wd <= '0;
      r_hold_wa <= '0;
      r_hold_mw <= 1'b0;
    end else if (FlushE) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_mw    <= 1'b0;
      r_wa    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!ValidD) begin
            r_valid <= 1'b0;
            r_mw    <= 1'b0;
            r_wa    <= '0;
          end else if (w_is_mul) begin
            r_hold_wd <= WriteDataD;
            r_hold_wa <= WA4D;
            r_hold_mw <= MemWriteD;
            r_valid   <= 1'b0;
            r_mw      <= 1'b0;
            r_wa      <= '0;
            r_state   <= ST_MUL;
          end else begin
            r_result <= w_res;
            r_flags  <= w_flags;
            r_valid  <= 1'b1;
            r_wa     <= WA4D;
            r_wdata  <= WriteDataD;
            r_mw     <= MemWriteD;
          end
        end
        ST_MUL: begin
          if (w_mul_done) begin
            r_result <= w_mul_prod;
            r_flags  <= w_mul_flags;
            r_valid  <= 1'b1;
            r_wa     <= r_hold_wa;
            r_wdata  <= r_hold_wd;
            r_mw     <= r_hold_mw;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ALUResultE = r_result;
  assign WriteDataE = r_wdata;
  assign WA4E       = r_wa;
  assign MemWriteE  = r_mw;
  assign ValidE     = r_valid;
  assign FlagsE     = r_flags;

endmodule

`default_nettype wire

// File: tb/tb_execute_stage.sv
// ============================================================================
// Module   : tb_execute_stage
// Purpose  : Self-checking bench for execute_stage (BITS=24): directed vector
//            table, randomized ops against an arithmetic reference model, and
//            hand sequences for reset, flush and multiply corner cases.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_execute_stage;

  localparam int BITS = 24;

  logic            CLK = 1'b0;
  logic            RST;
  logic            ValidD;
  logic [2:0]      ALUControlD;
  logic [BITS-1:0] SrcAD;
  logic [BITS-1:0] SrcBD;
  logic [BITS-1:0] WriteDataD;
  logic [3:0]      WA4D;
  logic            MemWriteD;
  logic            FlushE;
  logic            StallD;
  logic [BITS-1:0] ALUResultE;
  logic [BITS-1:0] WriteDataE;
  logic [3:0]      WA4E;
  logic            MemWriteE;
  logic            ValidE;
  logic [3:0]      FlagsE;

  int checks = 0;
  int errors = 0;
  logic [BITS-1:0] last_res = '0;
  logic [3:0]      last_fl  = '0;

  execute_stage #(.BITS(BITS)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .ValidD      (ValidD),
    .ALUControlD (ALUControlD),
    .SrcAD       (SrcAD),
    .SrcBD       (SrcBD),
    .WriteDataD  (WriteDataD),
    .WA4D        (WA4D),
    .MemWriteD   (MemWriteD),
    .FlushE      (FlushE),
    .StallD      (StallD),
    .ALUResultE  (ALUResultE),
    .WriteDataE  (WriteDataE),
    .WA4E        (WA4E),
    .MemWriteE   (MemWriteE),
    .ValidE      (ValidE),
    .FlagsE      (FlagsE)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]      op;
    logic [BITS-1:0] a;
    logic [BITS-1:0] b;
    logic [BITS-1:0] res;
    logic [3:0]      fl;   // {N,Z,C,V}
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on 24-bit values.
  function automatic void ref_model(input logic [2:0] op, input logic [BITS-1:0] a,
                                    input logic [BITS-1:0] b, output logic [BITS-1:0] res,
                                    output logic [3:0] fl);
    longint ua, ub, sa, sb, full, sres;
    int     amt;
    logic   c, v;
    ua   = longint'(a);
    ub   = longint'(b);
    sa   = a[BITS-1] ? ua - 64'sd16777216 : ua;
    sb   = b[BITS-1] ? ub - 64'sd16777216 : ub;
    amt  = int'(b[4:0]);
    c    = 1'b0;
    v    = 1'b0;
    full = 0;
    case (op)
      3'd0: begin
        full = ua + ub;
        c    = (full >= 64'sd16777216);
        sres = sa + sb;
        v    = (sres > 64'sd8388607) || (sres < -64'sd8388608);
      end
      3'd1: begin
        full = ua - ub;
        c    = (ua >= ub);
        sres = sa - sb;
        v    = (sres > 64'sd8388607) || (sres < -64'sd8388608);
      end
      3'd2: full = longint'(a & b);
      3'd3: full = longint'(a | b);
      3'd4: full = longint'(a ^ b);
      3'd5: full = (amt >= BITS) ? 0 : (ua << amt);
      3'd6: full = (amt >= BITS) ? 0 : (ua >> amt);
      default: full = ua * ub;
    endcase
    res = full[BITS-1:0];
    fl  = {res[BITS-1], (res == '0), c, v};
  endfunction

  // Present one instruction (called 1 time unit after a rising edge), behave
  // like decode by holding while StallD is high, then check the result that
  // appears once the instruction leaves execute. With scr set, the decode
  // inputs are scrambled during the multiply to prove they are ignored.
  task automatic do_op(input logic [2:0] op, input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                       input logic [3:0] wa, input logic [BITS-1:0] wd, input logic mw,
                       input logic scr, input logic [BITS-1:0] eres, input logic [3:0] efl);
    int   n;
    logic early;
    ValidD      = 1'b1;
    ALUControlD = op;
    SrcAD       = a;
    SrcBD       = b;
    WA4D        = wa;
    WriteDataD  = wd;
    MemWriteD   = mw;
    n           = 0;
    early       = 1'b0;
    #1;
    while (StallD && n < 100) begin
      n++;
      @(posedge CLK);
      #1;
      if (ValidE) early = 1'b1;
      if (scr) begin
        ValidD      = 1'($urandom);
        ALUControlD = 3'($urandom);
        SrcAD       = 24'($urandom);
        SrcBD       = 24'($urandom);
        WA4D        = 4'($urandom);
        WriteDataD  = 24'($urandom);
        MemWriteD   = 1'($urandom);
      end
      #1;
    end
    @(posedge CLK);
    #1;
    ValidD    = 1'b0;
    MemWriteD = 1'b0;
    chk("stall_cycles", 48'(n), (op == 3'd7) ? 48'd24 : 48'd0);
    chk("valid_early", 48'(early), 48'd0);
    chk("valid", 48'(ValidE), 48'd1);
    chk("result", 48'(ALUResultE), 48'(eres));
    chk("flags", 48'(FlagsE), 48'(efl));
    chk("wa4", 48'(WA4E), 48'(wa));
    chk("wdata", 48'(WriteDataE), 48'(wd));
    chk("memwrite", 48'(MemWriteE), 48'(mw));
    last_res = eres;
    last_fl  = efl;
  endtask

  task automatic bubble();
    ValidD = 1'b0;
    @(posedge CLK);
    #1;
    chk("bubble_valid", 48'(ValidE), 48'd0);
    chk("bubble_memwrite", 48'(MemWriteE), 48'd0);
    chk("bubble_wa4", 48'(WA4E), 48'd0);
    chk("bubble_result_hold", 48'(ALUResultE), 48'(last_res));
    chk("bubble_flags_hold", 48'(FlagsE), 48'(last_fl));
  endtask

  initial begin
    logic [2:0]      op;
    logic [BITS-1:0] a, b, eres;
    logic [3:0]      efl;
    logic            late;

    tbl[0]  = '{3'd0, 24'h7FFFFF, 24'h000001, 24'h800000, 4'b1001};
    tbl[1]  = '{3'd1, 24'h000005, 24'h000005, 24'h000000, 4'b0110};
    tbl[2]  = '{3'd7, 24'h000123, 24'h000045, 24'h004E6F, 4'b0000};
    tbl[3]  = '{3'd0, 24'hFFFFFF, 24'h000001, 24'h000000, 4'b0110};
    tbl[4]  = '{3'd1, 24'h000000, 24'h000001, 24'hFFFFFF, 4'b1000};
    tbl[5]  = '{3'd1, 24'h800000, 24'h000001, 24'h7FFFFF, 4'b0011};
    tbl[6]  = '{3'd2, 24'hF0F0F0, 24'hFF00FF, 24'hF000F0, 4'b1000};
    tbl[7]  = '{3'd3, 24'h000000, 24'h000000, 24'h000000, 4'b0100};
    tbl[8]  = '{3'd4, 24'hAAAAAA, 24'h555555, 24'hFFFFFF, 4'b1000};
    tbl[9]  = '{3'd5, 24'h000001, 24'h000017, 24'h800000, 4'b1000};
    tbl[10] = '{3'd5, 24'h000001, 24'h000018, 24'h000000, 4'b0100};
    tbl[11] = '{3'd6, 24'h800000, 24'h000017, 24'h000001, 4'b0000};
    tbl[12] = '{3'd6, 24'hFFFFFF, 24'h00001F, 24'h000000, 4'b0100};
    tbl[13] = '{3'd5, 24'h000003, 24'h000021, 24'h000006, 4'b0000};
    tbl[14] = '{3'd7, 24'h800000, 24'h000002, 24'h000000, 4'b0100};
    tbl[15] = '{3'd7, 24'hFFFFFF, 24'hFFFFFF, 24'h000001, 4'b0000};

    RST         = 1'b0;
    ValidD      = 1'b0;
    ALUControlD = '0;
    SrcAD       = '0;
    SrcBD       = '0;
    WriteDataD  = '0;
    WA4D        = '0;
    MemWriteD   = 1'b0;
    FlushE      = 1'b0;

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    #1;
    chk("rst_result", 48'(ALUResultE), 48'd0);
    chk("rst_wdata", 48'(WriteDataE), 48'd0);
    chk("rst_wa4", 48'(WA4E), 48'd0);
    chk("rst_memwrite", 48'(MemWriteE), 48'd0);
    chk("rst_valid", 48'(ValidE), 48'd0);
    chk("rst_flags", 48'(FlagsE), 48'd0);
    chk("rst_stall", 48'(StallD), 48'd0);
    @(posedge CLK);
    #1;

    // Directed table, issued back to back (MUL followed directly by ADD)
    for (int i = 0; i < 16; i++) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, 4'(i), 24'(i * 32'h111), 1'(i), 1'b0,
            tbl[i].res, tbl[i].fl);
    end
    bubble();

    // Flush at multiply iteration 10
    ValidD      = 1'b1;
    ALUControlD = 3'd7;
    SrcAD       = 24'h000123;
    SrcBD       = 24'h000045;
    MemWriteD   = 1'b1;
    repeat (11) @(posedge CLK);
    #1;
    FlushE = 1'b1;
    ValidD = 1'b0;
    #1;
    chk("flush_pre_stall", 48'(StallD), 48'd1);
    @(posedge CLK);
    #1;
    FlushE = 1'b0;
    chk("flush_valid", 48'(ValidE), 48'd0);
    chk("flush_stall", 48'(StallD), 48'd0);
    chk("flush_memwrite", 48'(MemWriteE), 48'd0);
    do_op(3'd0, 24'h000001, 24'h000002, 4'h5, 24'h00ABCD, 1'b0, 1'b0, 24'h000003, 4'b0000);
    late = 1'b0;
    repeat (30) begin
      @(posedge CLK);
      #1;
      if (ValidE) late = 1'b1;
    end
    chk("flush_no_late_valid", 48'(late), 48'd0);

    // Flush wins over a simultaneous instruction in IDLE
    ValidD      = 1'b1;
    ALUControlD = 3'd0;
    SrcAD       = 24'h000004;
    SrcBD       = 24'h000004;
    MemWriteD   = 1'b1;
    FlushE      = 1'b1;
    @(posedge CLK);
    #1;
    FlushE = 1'b0;
    ValidD = 1'b0;
    chk("flush_vs_valid_valid", 48'(ValidE), 48'd0);
    chk("flush_vs_valid_memwrite", 48'(MemWriteE), 48'd0);
    chk("flush_vs_valid_result_hold", 48'(ALUResultE), 48'(last_res));

    // Reset mid-multiply takes priority over flush and a valid ADD
    do_op(3'd0, 24'h00F000, 24'h000F00, 4'h9, 24'h123456, 1'b1, 1'b0, 24'h00FF00, 4'b0000);
    ValidD      = 1'b1;
    ALUControlD = 3'd7;
    SrcAD       = 24'h000003;
    SrcBD       = 24'h000005;
    repeat (6) @(posedge CLK);
    #1;
    RST         = 1'b0;
    FlushE      = 1'b1;
    ALUControlD = 3'd0;
    SrcAD       = 24'h000001;
    SrcBD       = 24'h000001;
    @(posedge CLK);
    #1;
    RST    = 1'b1;
    FlushE = 1'b0;
    ValidD = 1'b0;
    #1;
    chk("midmul_rst_valid", 48'(ValidE), 48'd0);
    chk("midmul_rst_result", 48'(ALUResultE), 48'd0);
    chk("midmul_rst_wa4", 48'(WA4E), 48'd0);
    chk("midmul_rst_wdata", 48'(WriteDataE), 48'd0);
    chk("midmul_rst_flags", 48'(FlagsE), 48'd0);
    chk("midmul_rst_stall", 48'(StallD), 48'd0);
    last_res = '0;
    last_fl  = '0;
    late = 1'b0;
    repeat (30) begin
      @(posedge CLK);
      #1;
      if (ValidE) late = 1'b1;
    end
    chk("midmul_rst_no_late_valid", 48'(late), 48'd0);

    // Randomized ops against the reference model
    for (int i = 0; i < 150; i++) begin
      op = 3'($urandom_range(0, 7));
      if (op == 3'd7 && $urandom_range(0, 2) != 0) op = 3'($urandom_range(0, 6));
      a = 24'($urandom);
      b = ($urandom_range(0, 3) == 0) ? 24'($urandom_range(0, 40)) : 24'($urandom);
      ref_model(op, a, b, eres, efl);
      do_op(op, a, b, 4'($urandom), 24'($urandom), 1'($urandom), 1'b1, eres, efl);
      if ($urandom_range(0, 3) == 0) bubble();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
